user_io_host: RTL and testbench

SPI master that drives the command/payload link into a core's user I/O SPI slave: it serialises one command byte followed by 0–3 payload bytes per frame. The link carries buttons/switches, joysticks, mouse, keyboard and OSD traffic, and the block captures the core-type byte returned on MISO. It sits on the riser/controller side, between the input-scanning logic and the SPI pins to the core FPGA.

---
 rtl/user_io_host.sv | 174 +++++++++++++++++
 tb/tb_user_io_host.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/user_io_host.sv
// SPI master for the user I/O link: sends one command byte plus 0-3 payload
// bytes per frame and captures the core-type byte returned during the command.
module user_io_host #(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ,
  input  logic [7:0]  CMD,
  input  logic [1:0]  LEN,
  input  logic [23:0] PAYLOAD,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  CORE_TYPE,
  output logic        SPI_CLK,
  output logic        SPI_SS_IO,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int GAP_W = $clog2(SS_GAP) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_TAIL,
    ST_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [4:0]        bit_q, bit_d;
  logic [1:0]        len_q, len_d;
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        miso_q, miso_d;
  logic [7:0]        core_type_q, core_type_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sck_q, sck_d;
  logic              ss_q, ss_d;
  logic              div_end;

  assign div_end = (div_q == '0);

  always_comb begin
    // NOTE: every _d starts from its _q (or a fixed value) so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    div_d       = div_q;
    gap_d       = gap_q;
    bit_d       = bit_q;
    len_d       = len_q;
    shift_d     = shift_q;
    miso_d      = miso_q;
    core_type_d = core_type_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sck_d       = sck_q;
    ss_d        = ss_q;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          shift_d = {CMD, PAYLOAD[7:0], PAYLOAD[15:8], PAYLOAD[23:16]};
          len_d   = LEN;
          bit_d   = '0;
          busy_d  = 1'b1;
          ss_d    = 1'b0;
          sck_d   = 1'b0;
          div_d   = DIV_LOAD;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (div_end) begin
          sck_d   = 1'b1;
          div_d   = DIV_LOAD;
          state_d = ST_HIGH;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (div_end) begin
          sck_d = 1'b0;
          div_d = DIV_LOAD;
          // Only the command-byte bits carry the core type.
          if (bit_q < 5'd8) miso_d = {miso_q[6:0], SPI_MISO};
          if (bit_q == {len_q, 3'b111}) begin
            state_d = ST_TAIL;
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[30:0], 1'b0};
            state_d = ST_LOW;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      ST_TAIL: begin
        if (div_end) begin
          ss_d    = 1'b1;
          div_d   = DIV_LOAD;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (div_end) begin
          div_d = DIV_LOAD;
          if (gap_q == '0) begin
            busy_d      = 1'b0;
            done_d      = 1'b1;
            core_type_d = miso_q;
            state_d     = ST_IDLE;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is asynchronous so a mid-frame reset drops SS/SCK at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      gap_q       <= '0;
      bit_q       <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      miso_q      <= '0;
      core_type_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sck_q       <= 1'b0;
      ss_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      bit_q       <= bit_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      miso_q      <= miso_d;
      core_type_q <= core_type_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sck_q       <= sck_d;
      ss_q        <= ss_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CORE_TYPE = core_type_q;
  assign SPI_CLK   = sck_q;
  assign SPI_SS_IO = ss_q;
  assign SPI_MOSI  = shift_q[31];

endmodule

// File: tb/tb_user_io_host.sv
// Directed bench for user_io_host with a mode-0 SPI slave model that records
// MOSI bits and returns a chosen byte on MISO.
module tb_user_io_host;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        REQ = 1'b0;
  logic [7:0]  CMD = 8'h00;
  logic [1:0]  LEN = 2'd0;
  logic [23:0] PAYLOAD = 24'h0;
  logic        BUSY, DONE, SPI_CLK, SPI_SS_IO, SPI_MOSI, SPI_MISO;
  logic [7:0]  CORE_TYPE;

  int n_vec = 0;
  int n_bad = 0;

  user_io_host #(.CLK_DIV(4), .SS_GAP(2)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .REQ       (REQ),
    .CMD       (CMD),
    .LEN       (LEN),
    .PAYLOAD   (PAYLOAD),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .CORE_TYPE (CORE_TYPE),
    .SPI_CLK   (SPI_CLK),
    .SPI_SS_IO (SPI_SS_IO),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO)
  );

  always #5 CLK = ~CLK;

  // Slave model: loads its reply at SS fall, shifts MISO on falling SCK,
  // samples MOSI on rising SCK.
  logic [7:0]  slave_tx = 8'h00;
  logic [7:0]  s_tx = 8'h00;
  logic [31:0] s_rx = 32'h0;
  int          s_rises = 0;
  logic        ss_l = 1'b1;
  logic        sck_l = 1'b0;
  int          viol = 0;

  assign SPI_MISO = s_tx[7];

  always @(SPI_SS_IO or SPI_CLK) begin
    if (!SPI_SS_IO && ss_l) begin
      s_tx    = slave_tx;
      s_rx    = 32'h0;
      s_rises = 0;
    end else if (SPI_CLK && !sck_l) begin
      s_rx = {s_rx[30:0], SPI_MOSI};
      s_rises++;
    end else if (!SPI_CLK && sck_l) begin
      s_tx = {s_tx[6:0], 1'b0};
    end
    ss_l  = SPI_SS_IO;
    sck_l = SPI_CLK;
  end

  always @(negedge CLK) if (SPI_CLK && SPI_SS_IO) viol++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [7:0] c, input logic [1:0] l, input logic [23:0] p);
    @(negedge CLK);
    CMD = c; LEN = l; PAYLOAD = p; REQ = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
    check("start_ss_low", SPI_SS_IO, 1'b0);
  endtask

  // Runs from the first negedge after acceptance to the negedge of the DONE cycle.
  task automatic wait_frame(input bit pulse, output int busy_n, output int done_n,
                            output bit done_fall, output bit ct_held, output int first_hi);
    logic [7:0] ct0;
    ct0 = CORE_TYPE;
    busy_n = 0; done_n = 0; done_fall = 1'b0; ct_held = 1'b1; first_hi = -1;
    for (int i = 0; i < 2000; i++) begin
      if (!BUSY) begin
        done_fall = DONE;
        if (DONE) done_n++;
        break;
      end
      busy_n++;
      if (DONE) done_n++;
      if (CORE_TYPE !== ct0) ct_held = 1'b0;
      if (SPI_CLK && first_hi < 0) first_hi = i;
      if (pulse) begin
        REQ = (i % 16 == 3);
        CMD = 8'hFF;
        LEN = 2'd3;
      end
      @(negedge CLK);
    end
    if (pulse) REQ = 1'b0;
  endtask

  initial begin
    int busy_n, done_n, first_hi, gap_n, done_seen;
    bit done_fall, ct_held;

    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      REQ = ~REQ;
      CMD = 8'h02;
    end
    REQ = 1'b0;
    check("rst_ss", SPI_SS_IO, 1'b1);
    check("rst_sck", SPI_CLK, 1'b0);
    check("rst_mosi", SPI_MOSI, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_core", CORE_TYPE, 8'h00);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    check("idle_busy", BUSY, 1'b0);
    check("idle_ss", SPI_SS_IO, 1'b1);

    // Joystick 0, one payload byte; slave answers 0xA5.
    slave_tx = 8'hA5;
    start(8'h02, 2'd1, 24'h000015);
    wait_frame(1'b0, busy_n, done_n, done_fall, ct_held, first_hi);
    check("joy_busy", busy_n, 140);
    check("joy_first_rise", first_hi, 4);
    check("joy_rises", s_rises, 16);
    check("joy_cmd", s_rx[15:8], 8'h02);
    check("joy_joy0", s_rx[5:0], 6'h15);
    check("joy_done_fall", done_fall, 1'b1);
    check("joy_done_cnt", done_n, 1);
    check("joy_core_held", ct_held, 1'b1);
    check("joy_core", CORE_TYPE, 8'hA5);
    @(negedge CLK);
    check("joy_done_pulse", DONE, 1'b0);

    // Mouse, three payload bytes; slave answers 0x3C.
    slave_tx = 8'h3C;
    start(8'h04, 2'd3, 24'h03FB05);
    wait_frame(1'b0, busy_n, done_n, done_fall, ct_held, first_hi);
    check("mouse_busy", busy_n, 268);
    check("mouse_rises", s_rises, 32);
    check("mouse_cmd", s_rx[31:24], 8'h04);
    check("mouse_data", {s_rx[15:8], s_rx[23:16]}, 16'hFB05);
    check("mouse_buttons", s_rx[2:0], 3'b011);
    check("mouse_core_held", ct_held, 1'b1);
    check("mouse_core", CORE_TYPE, 8'h3C);

    // REQ held high: second frame follows with the minimum SS gap.
    slave_tx = 8'h5A;
    @(negedge CLK);
    CMD = 8'h03; LEN = 2'd0; PAYLOAD = 24'h0; REQ = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!SPI_SS_IO) break;
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (SPI_SS_IO) break;
    end
    gap_n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!SPI_SS_IO) break;
      gap_n++;
      @(negedge CLK);
    end
    REQ = 1'b0;
    check("b2b_ss_gap", gap_n, 9);
    wait_frame(1'b0, busy_n, done_n, done_fall, ct_held, first_hi);
    check("b2b_busy", busy_n, 76);
    check("b2b_byte", s_rx[7:0], 8'h03);
    check("b2b_core", CORE_TYPE, 8'h5A);

    // REQ pulses while busy are ignored; REQ in the DONE cycle is taken.
    start(8'h05, 2'd0, 24'h0);
    wait_frame(1'b1, busy_n, done_n, done_fall, ct_held, first_hi);
    check("ign_busy", busy_n, 76);
    check("ign_rises", s_rises, 8);
    check("ign_byte", s_rx[7:0], 8'h05);
    check("ign_done_fall", done_fall, 1'b1);
    CMD = 8'h06; LEN = 2'd0; REQ = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
    check("dcyc_accept", BUSY, 1'b1);
    wait_frame(1'b0, busy_n, done_n, done_fall, ct_held, first_hi);
    check("dcyc_busy", busy_n, 76);
    check("dcyc_byte", s_rx[7:0], 8'h06);

    // Reset after the 10th SCK rise aborts the frame at once.
    slave_tx = 8'hC3;
    start(8'h04, 2'd3, 24'hFFFFFF);
    for (int i = 0; i < 1000; i++) begin
      if (s_rises >= 10) break;
      @(negedge CLK);
    end
    check("mid_rises", s_rises, 10);
    check("mid_sck_pre", SPI_CLK, 1'b1);
    RESET_N = 1'b0;
    #1;
    check("mid_ss", SPI_SS_IO, 1'b1);
    check("mid_sck", SPI_CLK, 1'b0);
    check("mid_busy", BUSY, 1'b0);
    check("mid_core", CORE_TYPE, 8'h00);
    done_seen = 0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    RESET_N = 1'b1;
    repeat (100) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    check("mid_no_done", done_seen, 0);

    // Buttons/switches frame after the aborted one.
    start(8'h01, 2'd1, 24'h00000A);
    wait_frame(1'b0, busy_n, done_n, done_fall, ct_held, first_hi);
    check("btn_busy", busy_n, 140);
    check("btn_cmd", s_rx[15:8], 8'h01);
    check("btn_buttons", s_rx[1:0], 2'b10);
    check("btn_switches", s_rx[3:2], 2'b10);
    check("sck_while_ss_high", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
